// File: rtl/xor_arbiter_pkg.sv
// Shared types and constants for the round-robin XOR arbiter.
package xor_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int COUNT_W   = 16;
    localparam int DEFAULT_N = 4;
    localparam int DEFAULT_W = 8;

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

endpackage

// File: rtl/xor_arbiter_rr_pick.sv
// Round-robin picker: first valid requester at or above rr_ptr, wrapping to 0.
module rr_pick
    import xor_arbiter_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic [N-1:0]         valid,
    input  logic [$clog2(N)-1:0] rr_ptr,
    input  logic                 enable,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 any
);

    localparam int IDX_W = $clog2(N);

    logic [IDX_W-1:0] idx;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path infers a latch.
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int i = 0; i < N; i++) begin
            // N is a power of two, so the IDX_W-bit sum wraps N-1 -> 0 on its own.
            idx = rr_ptr + IDX_W'(i);
            if (enable && !any && valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xor_arbiter.sv
// N requesters share one registered XOR unit; round-robin grant, one result per cycle.
module xor_arbiter
    import xor_arbiter_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = DEFAULT_W
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         io_req_valid,
    input  logic [N*W-1:0]       io_req_a,
    input  logic [N*W-1:0]       io_req_b,
    output logic [N-1:0]         io_req_ready,
    output logic                 io_resp_valid,
    input  logic                 io_resp_ready,
    output logic [W-1:0]         io_resp_data,
    output logic [$clog2(N)-1:0] io_resp_id,
    output logic [COUNT_W-1:0]   io_done_count
);

    localparam int IDX_W = $clog2(N);

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic             window_open;
    logic             accept;
    logic             handshake;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_idx;
    logic [W-1:0]     sel_a;
    logic [W-1:0]     sel_b;

    // Reset is folded in so no requester sees ready while the block is held in reset.
    assign window_open = !reset && ((state == IDLE) || io_resp_ready);

    rr_pick #(.N(N)) u_rr_pick (
        .valid     (io_req_valid),
        .rr_ptr    (rr_ptr),
        .enable    (window_open),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (accept)
    );

    assign io_req_ready  = grant;
    assign io_resp_valid = (state == HOLD);
    assign handshake     = io_resp_valid && io_resp_ready;

    assign sel_a = io_req_a[grant_idx*W +: W];
    assign sel_b = io_req_b[grant_idx*W +: W];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            io_resp_data  <= '0;
            io_resp_id    <= '0;
            io_done_count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (accept) begin
                state        <= HOLD;
                io_resp_data <= sel_a ^ sel_b;
                io_resp_id   <= grant_idx;
                rr_ptr       <= grant_idx + IDX_W'(1);
            end else if (handshake) begin
                state <= IDLE;
            end

            if (handshake && (io_done_count != COUNT_MAX)) begin
                io_done_count <= io_done_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: doc/xor_arbiter.md
XOR_ARBITER -- requirements
Module: xor_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters sharing the XOR unit, power of two, 2..8.
REQ-002 SHALL have parameter W, default 8: operand and result width in bits.
REQ-003 SHALL have port clock  input  1: single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port io_req_valid  input  N: bit i set means requester i offers an operand pair.
REQ-006 SHALL have port io_req_a  input  N*W: operand A, requester i at bits [i*W +: W].
REQ-007 SHALL have port io_req_b  input  N*W: operand B, same packing as io_req_a.
REQ-008 SHALL have port io_req_ready  output  N: one-hot or zero; bit i means requester i is accepted this cycle.
REQ-009 SHALL have port io_resp_valid  output  1: result held in io_resp_data is valid.
REQ-010 SHALL have port io_resp_ready  input  1: consumer accepts the result.
REQ-011 SHALL have port io_resp_data  output  W: registered A ^ B of the granted request.
REQ-012 SHALL have port io_resp_id  output  log2(N): index of the requester that owns io_resp_data.
REQ-013 SHALL have port io_done_count  output  16: number of completed response handshakes.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (no result held) and HOLD (result held, io_resp_valid=1).
REQ-015 Acceptance window SHALL be open when state==IDLE, or state==HOLD and io_resp_ready=1.
REQ-016 When the window is open and any io_req_valid bit is set, the grant SHALL be the first set bit scanning upward from rr_ptr, wrapping N-1 -> 0.
REQ-017 io_req_ready SHALL be combinational: only the granted bit, only while the window is open; otherwise all zero.
REQ-018 On acceptance of requester g, the block SHALL register io_resp_data <= a[g] ^ b[g], io_resp_id <= g, rr_ptr <= (g+1) mod N, and be in HOLD next cycle (latency one cycle).
REQ-019 In HOLD with io_resp_ready=1 and no request, the FSM SHALL return to IDLE and leave rr_ptr unchanged.
REQ-020 In HOLD with io_resp_ready=1 and a request, the response SHALL complete and the new request SHALL be accepted in the same cycle: state stays HOLD with new data; sustained throughput is one result per cycle.
REQ-021 In HOLD with io_resp_ready=0, io_resp_data and io_resp_id SHALL remain stable and io_req_ready SHALL be all zero.
REQ-022 io_done_count SHALL increment on every io_resp_valid & io_resp_ready cycle, saturating at 16'hFFFF.
REQ-023 Operand values of unaccepted requesters SHALL NOT affect any state; a requester dropping io_req_valid before acceptance SHALL be tolerated.
REQ-024 With a single persistent requester, it SHALL be granted every open window; with all N persistent, grants SHALL rotate 0,1,...,N-1,0 (no starvation, max wait N-1 grants).

Reset
REQ-025 Reset SHALL asynchronously force state=IDLE, rr_ptr=0, io_resp_valid=0, io_resp_data=0, io_resp_id=0, io_done_count=0.
REQ-026 Reset asserted in HOLD SHALL discard the held result without a handshake or count increment.
REQ-027 While reset is high, io_req_ready SHALL be all zero.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (IDLE, HOLD), the count width constant 16, and the default N and W.
REQ-029 The round-robin grant logic SHALL be a separate sub-module rr_pick (inputs: valid vector, rr_ptr, enable; outputs: one-hot grant, grant index, any).
REQ-030 The XOR datapath and result register SHALL stay in xor_arbiter.

Verification
REQ-031 Reset, then req_valid=4'b0010, a1=8'hF0, b1=8'h3C, resp_ready=1 -> ready=4'b0010 same cycle; next cycle resp_valid=1, data=8'hCC, id=1, done_count=1 after handshake.
REQ-032 All four valid persistently, resp_ready=1, a_i=i, b_i=8'hFF -> ids 0,1,2,3,0 on consecutive cycles, data 8'hFF,8'hFE,8'hFD,8'hFC.
REQ-033 HOLD with resp_ready=0 for 5 cycles while req_valid=4'b1111 -> req_ready=0, data/id stable, done_count unchanged.
REQ-034 rr_ptr=3, req_valid=4'b0101 -> grant requester 0, then requester 2 next.
REQ-035 Assert reset in HOLD -> resp_valid drops immediately (asynchronous), done_count=0, first post-reset grant is requester 0.
REQ-036 Force done_count to 16'hFFFE and complete 3 handshakes -> count reads 16'hFFFF.
